// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: state and
// length encodings, IO-region selector value and a zero word.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]  LEN_B    = 2'd0;
    localparam logic [1:0]  LEN_H    = 2'd1;
    localparam logic [1:0]  LEN_W    = 2'd3;
    localparam logic [1:0]  IO_SEL   = 2'b11;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Byte count for a length code; the unused code 2 behaves as a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   len_bytes = 3'd1;
            LEN_H:   len_bytes = 3'd2;
            default: len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// IDLE-state grant between load/store and fetch. Load/store has priority,
// fetch is masked by a redirect, and (with MEM_CTRL_IO_STALL_EN defined)
// an IO-region store is held off while the IO sink is full. A stalled
// store still blocks fetch so fetch cannot slip past it.
module mem_arbiter (
    input  logic flush,
    input  logic if_req,
    input  logic ls_req,
`ifdef MEM_CTRL_IO_STALL_EN
    input  logic ls_io_store,
    input  logic io_full,
`endif
    output logic grant_ls,
    output logic grant_if
);

    logic ls_stall;

    // Grant decode; only meaningful while the sequencer is idle.
    always_comb begin
`ifdef MEM_CTRL_IO_STALL_EN
        ls_stall = ls_io_store & io_full;
`else
        ls_stall = 1'b0;
`endif
        grant_ls = ls_req & ~ls_stall;
        grant_if = if_req & ~flush & ~ls_req;
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store, splits
// 1/2/4-byte accesses into per-byte RAM cycles and returns little-endian
// words with a one-cycle ready pulse.
// Optional build macro: MEM_CTRL_IO_STALL_EN (adds io_full_i stall of IO stores).
//
// state    | meaning
// ST_IDLE  | waiting for a request, RAM port quiet
// ST_READ  | issuing byte addresses and capturing returned bytes
// ST_WRITE | issuing byte writes
// ST_DONE  | one-cycle ready pulse to the owner
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int IO_SEL_HI = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ready_o,
    output logic [31:0]       if_inst_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [1:0]        ls_len_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [31:0]       ls_wdata_i,
    output logic              ls_ready_o,
    output logic [31:0]       ls_rdata_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_we_o,
`ifdef MEM_CTRL_IO_STALL_EN
    input  logic              io_full_i,
`endif
    input  logic [7:0]        ram_din_i,
    output logic              busy_o
);

    state_t            state, nxt;
    logic              owner_ls, we_q;
    logic [2:0]        n_q, cnt;
    logic [1:0]        cap_idx;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, asm_q, inst_hold, rdata_hold;
    logic              grant_ls, grant_if;

`ifdef MEM_CTRL_IO_STALL_EN
    logic ls_io_store;
    assign ls_io_store = ls_we_i & (ls_addr_i[IO_SEL_HI:IO_SEL_HI-1] == IO_SEL);
`endif

    mem_arbiter u_arb (
        .flush       (flush_i),
        .if_req      (if_req_i),
        .ls_req      (ls_req_i),
`ifdef MEM_CTRL_IO_STALL_EN
        .ls_io_store (ls_io_store),
        .io_full     (io_full_i),
`endif
        .grant_ls    (grant_ls),
        .grant_if    (grant_if)
    );

    // Byte i of a read arrives one cycle after its address, so the byte
    // landing while cnt=i+1 belongs in lane i (lane 3 when cnt wraps to 4).
    assign cap_idx = cnt[1:0] - 2'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    // Next-state decode and RAM/ready outputs.
    always_comb begin
        nxt        = state;
        ram_a_o    = '0;
        ram_dout_o = 8'h00;
        ram_we_o   = 1'b0;
        if_ready_o = 1'b0;
        ls_ready_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_ls)      nxt = ls_we_i ? ST_WRITE : ST_READ;
                else if (grant_if) nxt = ST_READ;
            end
            ST_READ: begin
                ram_a_o = addr_q + ADDR_W'(cnt);
                if (flush_i && !owner_ls) nxt = ST_IDLE;
                else if (cnt == n_q)      nxt = ST_DONE;
            end
            ST_WRITE: begin
                ram_a_o    = addr_q + ADDR_W'(cnt);
                ram_dout_o = wdata_q[{cnt[1:0], 3'b000} +: 8];
                ram_we_o   = 1'b1;
                if (cnt == n_q - 3'd1) nxt = ST_DONE;
            end
            ST_DONE: begin
                nxt = ST_IDLE;
                if (owner_ls)      ls_ready_o = 1'b1;
                else if (!flush_i) if_ready_o = 1'b1;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Request latch, byte counter, word assembly and held read results.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_ls   <= 1'b0;
            we_q       <= 1'b0;
            n_q        <= 3'd0;
            cnt        <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= ZeroWord;
            asm_q      <= ZeroWord;
            inst_hold  <= ZeroWord;
            rdata_hold <= ZeroWord;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_ls) begin
                        owner_ls <= 1'b1;
                        we_q     <= ls_we_i;
                        n_q      <= len_bytes(ls_len_i);
                        addr_q   <= ls_addr_i;
                        wdata_q  <= ls_wdata_i;
                        cnt      <= 3'd0;
                        asm_q    <= ZeroWord;
                    end else if (grant_if) begin
                        owner_ls <= 1'b0;
                        we_q     <= 1'b0;
                        n_q      <= 3'd4;
                        addr_q   <= if_addr_i;
                        cnt      <= 3'd0;
                        asm_q    <= ZeroWord;
                    end
                end
                ST_READ: begin
                    if (cnt != 3'd0) asm_q[{cap_idx, 3'b000} +: 8] <= ram_din_i;
                    cnt <= (nxt == ST_READ) ? cnt + 3'd1 : 3'd0;
                end
                ST_WRITE: begin
                    cnt <= (nxt == ST_WRITE) ? cnt + 3'd1 : 3'd0;
                end
                ST_DONE: begin
                    if (if_ready_o)             inst_hold  <= asm_q;
                    if (ls_ready_o && !we_q)    rdata_hold <= asm_q;
                end
                default: cnt <= 3'd0;
            endcase
        end
    end

    // Fresh data shows during the ready pulse and is held afterwards.
    assign if_inst_o  = if_ready_o ? asm_q : inst_hold;
    assign ls_rdata_o = (ls_ready_o && !we_q) ? asm_q : rdata_hold;
    assign busy_o     = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, scoreboard queues for RAM writes and
// ready data, per-scenario tasks with inline latency/state checks.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_inst;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_len = 2'd0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_ready;
    logic [31:0] ls_rdata;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic [7:0]  ram_din = 8'h00;
    logic        busy;
`ifdef MEM_CTRL_IO_STALL_EN
    logic        io_full = 1'b0;
`endif

    mem_ctrl #(.ADDR_W(32), .IO_SEL_HI(17)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_ready_o (if_ready),
        .if_inst_o  (if_inst),
        .ls_req_i   (ls_req),
        .ls_we_i    (ls_we),
        .ls_len_i   (ls_len),
        .ls_addr_i  (ls_addr),
        .ls_wdata_i (ls_wdata),
        .ls_ready_o (ls_ready),
        .ls_rdata_o (ls_rdata),
        .ram_a_o    (ram_a),
        .ram_dout_o (ram_dout),
        .ram_we_o   (ram_we),
`ifdef MEM_CTRL_IO_STALL_EN
        .io_full_i  (io_full),
`endif
        .ram_din_i  (ram_din),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // RAM model: preload image plus a written overlay, one-cycle read latency.
    logic [7:0] init_mem [0:4095];
    logic [7:0] wr_mem   [0:4095];
    bit         wr_valid [0:4095];

    always @(posedge clk) begin
        ram_din <= wr_valid[ram_a[11:0]] ? wr_mem[ram_a[11:0]] : init_mem[ram_a[11:0]];
        if (ram_we) begin
            wr_mem[ram_a[11:0]]   <= ram_dout;
            wr_valid[ram_a[11:0]] <= 1'b1;
        end
    end

    int          total = 0;
    int          bad = 0;
    logic [31:0] ifq[$];
    logic [31:0] lsq[$];
    logic [39:0] wq[$];
    logic [31:0] exp_ls_hold = '0;
    logic [31:0] if_last = '0;
    logic [31:0] ls_last = '0;
    logic [39:0] w_exp;
    bit          mon_on = 1'b0;
    logic        rst_q = 1'b1;

    always @(posedge clk) rst_q <= rst;

    // Scoreboard: RAM writes and ready data, plus hold of data between pulses.
    always @(negedge clk) begin
        if (rst_q) begin
            if_last = '0;
            ls_last = '0;
        end
        if (mon_on) begin
            if (ram_we) begin
                total++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL ram_write: unexpected write a=%h d=%h", ram_a, ram_dout);
                end else begin
                    w_exp = wq.pop_front();
                    if ({ram_a, ram_dout} !== w_exp) begin
                        bad++;
                        $display("FAIL ram_write: got a=%h d=%h want a=%h d=%h",
                                 ram_a, ram_dout, w_exp[39:8], w_exp[7:0]);
                    end
                end
            end
            total++;
            if (if_ready) begin
                if (ifq.size() == 0) begin
                    bad++;
                    $display("FAIL if_ready: unexpected pulse inst=%h", if_inst);
                end else begin
                    if_last = ifq.pop_front();
                    if (if_inst !== if_last) begin
                        bad++;
                        $display("FAIL if_inst: got %h want %h", if_inst, if_last);
                    end
                end
            end else if (if_inst !== if_last) begin
                bad++;
                $display("FAIL if_inst_hold: got %h want %h", if_inst, if_last);
            end
            total++;
            if (ls_ready) begin
                if (lsq.size() == 0) begin
                    bad++;
                    $display("FAIL ls_ready: unexpected pulse rdata=%h", ls_rdata);
                end else begin
                    ls_last = lsq.pop_front();
                    if (ls_rdata !== ls_last) begin
                        bad++;
                        $display("FAIL ls_rdata: got %h want %h", ls_rdata, ls_last);
                    end
                end
            end else if (ls_rdata !== ls_last) begin
                bad++;
                $display("FAIL ls_rdata_hold: got %h want %h", ls_rdata, ls_last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one load/store, return cycles from request to ls_ready, end in IDLE.
    task automatic do_ls(input logic we, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp, output int lat);
        int n;
        n = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        if (we) begin
            for (int i = 0; i < n; i++) wq.push_back({addr + 32'(i), wdata[8*i +: 8]});
            lsq.push_back(exp_ls_hold);
        end else begin
            lsq.push_back(exp);
            exp_ls_hold = exp;
        end
        ls_we = we; ls_len = len; ls_addr = addr; ls_wdata = wdata; ls_req = 1'b1;
        lat = -1;
        for (int c = 1; c <= 30 && lat < 0; c++) begin
            tick();
            if (ls_ready) lat = c;
        end
        ls_req = 1'b0;
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL ls_timeout: no ls_ready addr=%h", addr);
        end
        tick();
    endtask

    task automatic do_if(input logic [31:0] addr, input logic [31:0] exp, output int lat);
        ifq.push_back(exp);
        if_addr = addr; if_req = 1'b1;
        lat = -1;
        for (int c = 1; c <= 30 && lat < 0; c++) begin
            tick();
            if (if_ready) lat = c;
        end
        if_req = 1'b0;
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL if_timeout: no if_ready addr=%h", addr);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (ram_we !== 1'b0)    begin bad++; $display("FAIL reset_we: got %b want 0", ram_we); end
        total++; if (ram_a !== 32'h0)    begin bad++; $display("FAIL reset_a: got %h want 0", ram_a); end
        total++; if (ram_dout !== 8'h0)  begin bad++; $display("FAIL reset_dout: got %h want 0", ram_dout); end
        total++; if (if_ready !== 1'b0 || ls_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready: got %b%b want 00", if_ready, ls_ready); end
        total++; if (if_inst !== 32'h0 || ls_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_data: got %h %h want 0 0", if_inst, ls_rdata); end
        exp_ls_hold = '0;
        mon_on = 1'b1;
    endtask

    task automatic test_if_read();
        int lat;
        ifq.push_back(32'h0000_0513);
        if_addr = 32'h100; if_req = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            tick();
            if (c <= 4) begin
                total++;
                if (ram_a !== 32'h100 + 32'(c - 1) || ram_we !== 1'b0) begin
                    bad++;
                    $display("FAIL if_read_addr: cycle %0d got a=%h we=%b want a=%h we=0",
                             c, ram_a, ram_we, 32'h100 + 32'(c - 1));
                end
            end
            if (if_ready) lat = c;
        end
        if_req = 1'b0;
        total++; if (lat !== 6) begin bad++; $display("FAIL if_read_lat: got %0d want 6", lat); end
        tick();
    endtask

    task automatic test_store_word();
        int lat;
        do_ls(1'b1, LEN_W, 32'h20, 32'hDEAD_BEEF, 32'h0, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL store_lat: got %0d want 5", lat); end
        do_ls(1'b0, LEN_W, 32'h20, 32'h0, 32'hDEAD_BEEF, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL load_word_lat: got %0d want 6", lat); end
    endtask

    task automatic test_arbitration();
        int ls_lat, if_lat;
        lsq.push_back(32'h0000_00FF); exp_ls_hold = 32'h0000_00FF;
        ifq.push_back(32'h0000_0093);
        if_addr = 32'h0; if_req = 1'b1;
        ls_we = 1'b0; ls_len = LEN_B; ls_addr = 32'h40; ls_req = 1'b1;
        ls_lat = -1; if_lat = -1;
        for (int c = 1; c <= 30 && if_lat < 0; c++) begin
            tick();
            if (c == 1) begin
                total++;
                if (ram_a !== 32'h40) begin bad++; $display("FAIL arb_first: got a=%h want 00000040", ram_a); end
            end
            if (ls_ready && ls_lat < 0) begin ls_lat = c; ls_req = 1'b0; end
            if (if_ready) begin if_lat = c; if_req = 1'b0; end
        end
        if_req = 1'b0; ls_req = 1'b0;
        total++; if (ls_lat !== 3)  begin bad++; $display("FAIL arb_ls_lat: got %0d want 3", ls_lat); end
        total++; if (if_lat !== 10) begin bad++; $display("FAIL arb_if_lat: got %0d want 10", if_lat); end
        tick();
    endtask

    task automatic test_flush();
        int lat;
        if_addr = 32'h8; if_req = 1'b1;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle: got busy=%b want 0", busy); end
        if_addr = 32'h40;
        ifq.push_back(32'h0302_01FF);
        lat = -1;
        for (int c = 5; c <= 30 && lat < 0; c++) begin
            tick();
            if (if_ready) lat = c;
        end
        if_req = 1'b0;
        total++; if (lat !== 10) begin bad++; $display("FAIL flush_refetch_lat: got %0d want 10", lat); end
        tick();
        // flush masks fetch in IDLE but not load/store
        flush = 1'b1; if_req = 1'b1; if_addr = 32'h100;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_mask_if: got busy=%b want 0", busy); end
        do_ls(1'b0, LEN_B, 32'h40, 32'h0, 32'h0000_00FF, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL flush_ls_lat: got %0d want 3", lat); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_mask_if2: got busy=%b want 0", busy); end
        flush = 1'b0; if_req = 1'b0;
        do_if(32'h100, 32'h0000_0513, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL if_after_flush_lat: got %0d want 6", lat); end
    endtask

    task automatic test_lengths();
        int lat;
        do_ls(1'b0, LEN_H, 32'hFFFF_FFFF, 32'h0, 32'h0000_9334, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL half_wrap_lat: got %0d want 4", lat); end
        do_ls(1'b1, 2'd2, 32'h50, 32'h1122_3344, 32'h0, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL len2_store_lat: got %0d want 5", lat); end
        do_ls(1'b0, LEN_B, 32'h51, 32'h0, 32'h0000_0033, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL byte_load_lat: got %0d want 3", lat); end
        do_ls(1'b1, LEN_B, 32'h53, 32'hAABB_CCDD, 32'h0, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL byte_store_lat: got %0d want 2", lat); end
        do_ls(1'b0, LEN_W, 32'h50, 32'h0, 32'hDD22_3344, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL word_readback_lat: got %0d want 6", lat); end
    endtask

    task automatic test_reset_mid();
        int lat;
        wq.push_back({32'h60, 8'h88});
        wq.push_back({32'h61, 8'h77});
        ls_we = 1'b1; ls_len = LEN_W; ls_addr = 32'h60; ls_wdata = 32'h5566_7788; ls_req = 1'b1;
        tick(); tick();
        rst = 1'b1; ls_req = 1'b0;
        tick();
        total++; if (ram_we !== 1'b0)   begin bad++; $display("FAIL rst_mid_we: got %b want 0", ram_we); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        total++; if (ls_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready: got %b want 0", ls_ready); end
        total++; if (ls_rdata !== 32'h0 || if_inst !== 32'h0) begin
            bad++; $display("FAIL rst_mid_data: got %h %h want 0 0", ls_rdata, if_inst); end
        exp_ls_hold = '0;
        rst = 1'b0;
        tick();
        do_ls(1'b0, LEN_W, 32'h60, 32'h0, 32'hA4A3_7788, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL rst_mid_readback_lat: got %0d want 6", lat); end
    endtask

`ifdef MEM_CTRL_IO_STALL_EN
    task automatic test_io_stall();
        int ls_lat, if_lat;
        io_full = 1'b1;
        wq.push_back({32'h0003_0000, 8'h5A});
        lsq.push_back(exp_ls_hold);
        ifq.push_back(32'h0000_0513);
        ls_we = 1'b1; ls_len = LEN_B; ls_addr = 32'h0003_0000; ls_wdata = 32'h0000_005A; ls_req = 1'b1;
        if_addr = 32'h100; if_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            total++;
            if (busy !== 1'b0 || ram_we !== 1'b0) begin
                bad++; $display("FAIL io_stall: cycle %0d got busy=%b we=%b want 0 0", c, busy, ram_we);
            end
        end
        io_full = 1'b0;
        ls_lat = -1; if_lat = -1;
        for (int c = 1; c <= 30 && if_lat < 0; c++) begin
            tick();
            if (ls_ready && ls_lat < 0) begin ls_lat = c; ls_req = 1'b0; end
            if (if_ready) begin if_lat = c; if_req = 1'b0; end
        end
        ls_req = 1'b0; if_req = 1'b0;
        total++; if (ls_lat !== 2) begin bad++; $display("FAIL io_ls_lat: got %0d want 2", ls_lat); end
        total++; if (if_lat !== 9) begin bad++; $display("FAIL io_if_lat: got %0d want 9", if_lat); end
        tick();
    endtask
`else
    task automatic test_io_stall();
        int lat;
        do_ls(1'b1, LEN_B, 32'h0003_0000, 32'h0000_005A, 32'h0, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL io_store_lat: got %0d want 2", lat); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4096; i++) init_mem[i] = 8'h00;
        init_mem[12'h100] = 8'h13; init_mem[12'h101] = 8'h05;
        init_mem[12'h102] = 8'h00; init_mem[12'h103] = 8'h00;
        init_mem[12'h000] = 8'h93;
        init_mem[12'h040] = 8'hFF; init_mem[12'h041] = 8'h01;
        init_mem[12'h042] = 8'h02; init_mem[12'h043] = 8'h03;
        init_mem[12'hFFF] = 8'h34;
        init_mem[12'h060] = 8'hA1; init_mem[12'h061] = 8'hA2;
        init_mem[12'h062] = 8'hA3; init_mem[12'h063] = 8'hA4;

        test_reset();
        test_if_read();
        test_store_word();
        test_arbitration();
        test_flush();
        test_lengths();
        test_reset_mid();
        test_io_stall();
        repeat (3) tick();

        total++; if (wq.size() != 0)  begin bad++; $display("FAIL leftover_writes: got %0d want 0", wq.size()); end
        total++; if (ifq.size() != 0) begin bad++; $display("FAIL leftover_if: got %0d want 0", ifq.size()); end
        total++; if (lsq.size() != 0) begin bad++; $display("FAIL leftover_ls: got %0d want 0", lsq.size()); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
